// File: rtl/seg7_mux.sv
// rtl/seg7_mux.sv - two-digit multiplexed seven-segment driver with dead time, PWM dimming and double-buffered data
module seg7_mux #(
    parameter int DigitCycles = 25000,
    parameter int BlankCycles = 500
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_i,
    input  logic [7:0] value_i,
    input  logic [1:0] blank_i,
    input  logic       valid_i,
    input  logic [3:0] brightness_i,
    output logic [6:0] seg_o,
    output logic       sel_o,
    output logic       frame_start_o
);

    localparam int MaxCycles = (DigitCycles > BlankCycles) ? DigitCycles : BlankCycles;
    localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] DigitLast = CntW'(DigitCycles - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BlankCycles - 1);

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_end;
    logic            frame_end;
    logic [3:0]      pwm_q, pwm_d;

    logic [7:0]      pend_value_q;
    logic [1:0]      pend_blank_q;
    logic            pend_flag_q;
    logic [7:0]      shadow_value_q;
    logic [1:0]      shadow_blank_q;

    logic [3:0]      digit;
    logic            digit_blank;
    logic [6:0]      decoded;
    logic [6:0]      seg_d;
    logic            sel_d;

    // Next-state and phase counter: each state runs for its length, then the counter restarts
    always_comb begin
        state_d   = state_q;
        phase_end = 1'b0;
        cnt_d     = cnt_q + CntW'(1);
        case (state_q)
            BLANK0: begin
                phase_end = (cnt_q == BlankLast);
                if (phase_end) state_d = SHOW0;
            end
            SHOW0: begin
                phase_end = (cnt_q == DigitLast);
                if (phase_end) state_d = BLANK1;
            end
            BLANK1: begin
                phase_end = (cnt_q == BlankLast);
                if (phase_end) state_d = SHOW1;
            end
            SHOW1: begin
                phase_end = (cnt_q == DigitLast);
                if (phase_end) state_d = BLANK0;
            end
            default: state_d = BLANK0;
        endcase
        if (phase_end) cnt_d = '0;
        frame_end = (state_q == SHOW1) && phase_end;
        pwm_d     = pwm_q + 4'd1;
    end

    // Output selection, computed for the state being entered so registered outputs line up with it
    always_comb begin
        sel_d       = (state_d == BLANK1) || (state_d == SHOW1);
        digit       = sel_d ? shadow_value_q[7:4] : shadow_value_q[3:0];
        digit_blank = sel_d ? shadow_blank_q[1] : shadow_blank_q[0];
        case (digit)
            4'h0: decoded = 7'h3F;
            4'h1: decoded = 7'h06;
            4'h2: decoded = 7'h5B;
            4'h3: decoded = 7'h4F;
            4'h4: decoded = 7'h66;
            4'h5: decoded = 7'h6D;
            4'h6: decoded = 7'h7D;
            4'h7: decoded = 7'h07;
            4'h8: decoded = 7'h7F;
            4'h9: decoded = 7'h6F;
            4'hA: decoded = 7'h77;
            4'hB: decoded = 7'h7C;
            4'hC: decoded = 7'h39;
            4'hD: decoded = 7'h5E;
            4'hE: decoded = 7'h79;
            default: decoded = 7'h71;
        endcase
        seg_d = 7'h00;
        if (((state_d == SHOW0) || (state_d == SHOW1)) && !digit_blank && (pwm_d <= brightness_i)) begin
            seg_d = decoded;
        end
    end

    // State, phase counter, free-running PWM counter and registered outputs
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q       <= BLANK0;
            cnt_q         <= '0;
            pwm_q         <= 4'd0;
            seg_o         <= 7'h00;
            sel_o         <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            seg_o         <= seg_d;
            sel_o         <= sel_d;
            frame_start_o <= frame_end;
        end
    end

    // Double buffer: strobes land in pending; shadow only moves at the frame boundary so a frame never tears
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            pend_value_q   <= 8'h00;
            pend_blank_q   <= 2'b11;
            pend_flag_q    <= 1'b0;
            shadow_value_q <= 8'h00;
            shadow_blank_q <= 2'b11;
        end else begin
            if (frame_end && pend_flag_q) begin
                shadow_value_q <= pend_value_q;
                shadow_blank_q <= pend_blank_q;
                pend_flag_q    <= 1'b0;
            end
            if (valid_i) begin
                pend_value_q <= value_i;
                pend_blank_q <= blank_i;
                pend_flag_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_mux.sv
// tb/tb_seg7_mux.sv - scoreboard bench for seg7_mux against a frame-position reference model
module tb_seg7_mux;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic [1:0] blank;
    logic       valid;
    logic [3:0] brightness;
    logic [6:0] seg;
    logic       sel;
    logic       frame_start;

    seg7_mux #(
        .DigitCycles(8),
        .BlankCycles(2)
    ) dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .value_i      (value),
        .blank_i      (blank),
        .valid_i      (valid),
        .brightness_i (brightness),
        .seg_o        (seg),
        .sel_o        (sel),
        .frame_start_o(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [8:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    // Reference model: k counts clock edges since the last reset edge; frame position is k mod 20
    int         k        = 0;
    logic [7:0] sh_val   = 8'h00;
    logic [1:0] sh_blk   = 2'b11;
    logic [7:0] p_val    = 8'h00;
    logic [1:0] p_blk    = 2'b11;
    logic       pflag    = 1'b0;
    logic [3:0] bri_cur  = 4'd15;

    task automatic step(input logic r, input logic v, input logic [7:0] val,
                        input logic [1:0] blk, input logic [3:0] bri);
        int         pos;
        int         d;
        logic       show;
        logic       s_sel;
        logic [3:0] nib;
        logic [6:0] s;
        @(negedge clk);
        rst        = r;
        valid      = v;
        value      = val;
        blank      = blk;
        brightness = bri;
        if (r) begin
            k      = 0;
            sh_val = 8'h00;
            sh_blk = 2'b11;
            pflag  = 1'b0;
            exp_q.push_back(9'h000);
        end else begin
            k   = k + 1;
            pos = k % 20;
            if (pos == 0 && pflag) begin
                sh_val = p_val;
                sh_blk = p_blk;
                pflag  = 1'b0;
            end
            if (v) begin
                p_val = val;
                p_blk = blk;
                pflag = 1'b1;
            end
            s_sel = (pos >= 10);
            show  = ((pos % 10) >= 2);
            d     = s_sel ? 1 : 0;
            nib   = s_sel ? sh_val[7:4] : sh_val[3:0];
            s     = (show && !sh_blk[d] && ((k % 16) <= int'(bri))) ? lut[nib] : 7'h00;
            exp_q.push_back({(pos == 0), s_sel, s});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 3), bri_cur);
    endtask

    task automatic idle_until(input int p);
        while (((k + 1) % 20) != p) step(1'b0, 1'b0, 8'h00, 2'b00, bri_cur);
    endtask

    task automatic load(input logic [7:0] val, input logic [1:0] blk);
        step(1'b0, 1'b1, val, blk, bri_cur);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if ({frame_start, sel, seg} === e) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL outputs cycle %0d: got seg=%h sel=%b frame_start=%b, want seg=%h sel=%b frame_start=%b",
                         cyc, seg, sel, frame_start, e[6:0], e[7], e[8]);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        valid      = 1'b0;
        value      = 8'h00;
        blank      = 2'b00;
        brightness = 4'd15;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 2'b00, 4'd15);

        bri_cur = 4'd15;
        idle(100);

        load(8'h3A, 2'b00);
        idle(45);

        bri_cur = 4'd3;
        idle(40);
        bri_cur = 4'd15;

        idle_until(4);
        load(8'h11, 2'b00);
        idle(30);
        idle_until(3);
        load(8'h22, 2'b00);
        idle(5);
        load(8'h33, 2'b00);
        idle(45);

        while (!(((k + 1) % 20) == 0 && !pflag)) step(1'b0, 1'b0, 8'h00, 2'b00, bri_cur);
        load(8'h55, 2'b00);
        idle(45);

        load(8'h7E, 2'b10);
        idle(45);

        idle_until(15);
        step(1'b1, 1'b0, 8'h00, 2'b00, bri_cur);
        idle(45);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 15));
        end

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks = n_checks + 1;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
